mac_accumulator_stage: RTL and testbench

Downstream consumer of the generic pipelined multiplier. It takes the 2*WIDTH-bit product stream, sums fixed-length groups of LEN products into dot-product results, and presents each result through a one-entry valid/ready output register. It detects accumulator overflow and flags products dropped because the upstream pipeline has no stall path.

---
 rtl/mac_accumulator_stage.sv | 215 +++++++++++++++++++++
 tb/tb_mac_accumulator_stage.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mac_accumulator_stage.sv
// -----------------------------------------------------------------------------
// mac_accumulator_stage
//
// Purpose:
//   Consumes the product stream of a pipelined multiplier and adds fixed-size
//   groups of LEN products into dot-product results. Each finished group sum is
//   presented through a one-entry valid/ready output register. The stage also
//   detects when a group sum wraps past ACC_WIDTH bits. It keeps a sticky flag
//   for products that were dropped because the upstream multiplier cannot stall.
//
// Parameters:
//   WIDTH      multiplier operand width; products are 2*WIDTH bits
//   LEN        products per group (>= 1)
//   ACC_WIDTH  accumulator / result width (>= 2*WIDTH)
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous active-high reset, overrides every other input
//   in_valid      a product is present on in_product this cycle
//   in_product    unsigned product from the multiplier
//   in_ready      stage can accept a product (combinational)
//   clr           synchronous abort of the partial group
//   out_valid     result register holds a result
//   out_ready     downstream accepts the result
//   out_sum       group sum (modulo 2^ACC_WIDTH)
//   out_overflow  group sum wrapped past ACC_WIDTH bits
//   err_drop      sticky: a product arrived while in_ready was low
// -----------------------------------------------------------------------------
module mac_accumulator_stage #(
  parameter int WIDTH     = 8,
  parameter int LEN       = 4,
  parameter int ACC_WIDTH = 2 * WIDTH + $clog2(LEN)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [2*WIDTH-1:0]     in_product,
  output logic                   in_ready,
  input  logic                   clr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_WIDTH-1:0]   out_sum,
  output logic                   out_overflow,
  output logic                   err_drop
);

  localparam int PW = 2 * WIDTH;
  // A LEN of 1 still needs a one-bit counter so the vectors stay legal.
  localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEN - 1);

  // Group FSM encoding
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] ACC  = 1'b1;

  // Registered state
  logic [0:0]           state_r;
  logic [ACC_WIDTH-1:0] acc_r;
  logic [CNT_W-1:0]     cnt_r;
  logic                 ovf_r;
  logic                 out_valid_r;
  logic [ACC_WIDTH-1:0] out_sum_r;
  logic                 out_overflow_r;
  logic                 err_drop_r;

  // Combinational datapath
  logic                 in_ready_s;
  logic                 accept_s;
  logic [ACC_WIDTH-1:0] base_acc_s;
  logic [CNT_W-1:0]     base_cnt_s;
  logic                 base_ovf_s;
  logic [ACC_WIDTH:0]   sum_s;
  logic                 last_s;
  logic                 load_s;
  logic [ACC_WIDTH-1:0] acc_nxt_s;
  logic [CNT_W-1:0]     cnt_nxt_s;
  logic                 ovf_nxt_s;
  logic [0:0]           state_nxt_s;
  logic                 res_ovf_s;

  // A full result register blocks the input until downstream takes it.
  always_comb begin
    in_ready_s = !(out_valid_r && !out_ready);
    accept_s   = in_valid && in_ready_s;
  end

  // clr discards the old partial group. The product accepted on the same edge
  // then starts a new group, so the adder sees a zeroed base.
  always_comb begin
    if (clr) begin
      base_acc_s = {ACC_WIDTH{1'b0}};
      base_cnt_s = {CNT_W{1'b0}};
      base_ovf_s = 1'b0;
    end else begin
      base_acc_s = acc_r;
      base_cnt_s = cnt_r;
      base_ovf_s = ovf_r;
    end
  end

  // One extra adder bit captures the carry that marks a wrap.
  always_comb begin
    sum_s     = {1'b0, base_acc_s} + {{(ACC_WIDTH + 1 - PW){1'b0}}, in_product};
    last_s    = (base_cnt_s == LAST_CNT);
    res_ovf_s = base_ovf_s | sum_s[ACC_WIDTH];
  end

  // Accumulator and counter update. Completing a group resets them, so the next
  // product starts a new group with no bubble.
  always_comb begin
    acc_nxt_s = base_acc_s;
    cnt_nxt_s = base_cnt_s;
    ovf_nxt_s = base_ovf_s;
    load_s    = 1'b0;
    if (accept_s) begin
      if (last_s) begin
        acc_nxt_s = {ACC_WIDTH{1'b0}};
        cnt_nxt_s = {CNT_W{1'b0}};
        ovf_nxt_s = 1'b0;
        load_s    = 1'b1;
      end else begin
        acc_nxt_s = sum_s[ACC_WIDTH-1:0];
        cnt_nxt_s = base_cnt_s + CNT_W'(1);
        ovf_nxt_s = res_ovf_s;
      end
    end else begin
      acc_nxt_s = base_acc_s;
      cnt_nxt_s = base_cnt_s;
      ovf_nxt_s = base_ovf_s;
    end
  end

  // Group FSM: IDLE has no partial group, ACC holds one.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        // With LEN=1 every product completes immediately, so IDLE is kept.
        if (accept_s && !last_s) begin
          state_nxt_s = ACC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ACC: begin
        if (accept_s) begin
          state_nxt_s = last_s ? IDLE : ACC;
        end else if (clr) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = ACC;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Group state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      acc_r   <= {ACC_WIDTH{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      ovf_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      acc_r   <= acc_nxt_s;
      cnt_r   <= cnt_nxt_s;
      ovf_r   <= ovf_nxt_s;
    end
  end

  // One-entry result register. A push on the same edge as a pop wins, so
  // back-to-back groups keep out_valid high.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r    <= 1'b0;
      out_sum_r      <= {ACC_WIDTH{1'b0}};
      out_overflow_r <= 1'b0;
    end else if (load_s) begin
      out_valid_r    <= 1'b1;
      out_sum_r      <= sum_s[ACC_WIDTH-1:0];
      out_overflow_r <= res_ovf_s;
    end else if (out_valid_r && out_ready) begin
      out_valid_r    <= 1'b0;
      out_sum_r      <= out_sum_r;
      out_overflow_r <= out_overflow_r;
    end else begin
      out_valid_r    <= out_valid_r;
      out_sum_r      <= out_sum_r;
      out_overflow_r <= out_overflow_r;
    end
  end

  // Sticky drop flag. The multiplier cannot stall, so a product offered while
  // the stage is blocked is lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_drop_r <= 1'b0;
    end else if (in_valid && !in_ready_s) begin
      err_drop_r <= 1'b1;
    end else begin
      err_drop_r <= err_drop_r;
    end
  end

  assign in_ready     = in_ready_s;
  assign out_valid    = out_valid_r;
  assign out_sum      = out_sum_r;
  assign out_overflow = out_overflow_r;
  assign err_drop     = err_drop_r;

endmodule

// File: tb/tb_mac_accumulator_stage.sv
// -----------------------------------------------------------------------------
// tb_mac_accumulator_stage
//
// Drives two instances of mac_accumulator_stage:
//   instance 0 uses the defaults (LEN=4, ACC_WIDTH=18).
//   instance 1 uses LEN=2 and ACC_WIDTH=16, so that overflow occurs.
// The reference model keeps the true (unbounded) running sum of the current
// group and reduces it modulo 2^ACC_WIDTH only when the group completes.
// -----------------------------------------------------------------------------
module tb_mac_accumulator_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a  [2];
  logic        vld_a  [2];
  logic        clr_a  [2];
  logic        ordy_a [2];
  logic [15:0] prod_a [2];

  logic        d0_in_ready, d0_out_valid, d0_out_overflow, d0_err_drop;
  logic [17:0] d0_out_sum;
  logic        d1_in_ready, d1_out_valid, d1_out_overflow, d1_err_drop;
  logic [15:0] d1_out_sum;

  mac_accumulator_stage u_dut0 (
    .clk          (clk),
    .rst          (rst_a[0]),
    .in_valid     (vld_a[0]),
    .in_product   (prod_a[0]),
    .in_ready     (d0_in_ready),
    .clr          (clr_a[0]),
    .out_valid    (d0_out_valid),
    .out_ready    (ordy_a[0]),
    .out_sum      (d0_out_sum),
    .out_overflow (d0_out_overflow),
    .err_drop     (d0_err_drop)
  );

  mac_accumulator_stage #(.WIDTH(8), .LEN(2), .ACC_WIDTH(16)) u_dut1 (
    .clk          (clk),
    .rst          (rst_a[1]),
    .in_valid     (vld_a[1]),
    .in_product   (prod_a[1]),
    .in_ready     (d1_in_ready),
    .clr          (clr_a[1]),
    .out_valid    (d1_out_valid),
    .out_ready    (ordy_a[1]),
    .out_sum      (d1_out_sum),
    .out_overflow (d1_out_overflow),
    .err_drop     (d1_err_drop)
  );

  // Reference model state
  int     lens [2] = '{4, 2};
  int     aws  [2] = '{18, 16};
  bit     m_ov  [2];
  longint m_sum [2];
  bit     m_of  [2];
  bit     m_err [2];
  longint g_sum [2];
  int     g_n   [2];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic bit m_ready(input int id);
    return !(m_ov[id] && !ordy_a[id]);
  endfunction

  // Advance the model of one instance by one clock edge.
  task automatic model_step(input int id);
    bit rdy;
    rdy = m_ready(id);
    if (rst_a[id]) begin
      m_ov[id] = 0; m_sum[id] = 0; m_of[id] = 0; m_err[id] = 0;
      g_sum[id] = 0; g_n[id] = 0;
    end else begin
      if (vld_a[id] && !rdy) m_err[id] = 1;
      if (clr_a[id]) begin g_sum[id] = 0; g_n[id] = 0; end
      if (m_ov[id] && ordy_a[id]) m_ov[id] = 0;
      if (vld_a[id] && rdy) begin
        g_sum[id] += longint'(prod_a[id]);
        g_n[id]++;
        if (g_n[id] == lens[id]) begin
          m_ov[id]  = 1;
          m_sum[id] = g_sum[id] % (longint'(1) << aws[id]);
          m_of[id]  = (g_sum[id] >= (longint'(1) << aws[id]));
          g_sum[id] = 0;
          g_n[id]   = 0;
        end
      end
    end
  endtask

  // One clock: check the comb ready, step across the edge, check the registers.
  task automatic cycle();
    #1;
    check("in_ready0", longint'(d0_in_ready), longint'(m_ready(0)));
    check("in_ready1", longint'(d1_in_ready), longint'(m_ready(1)));
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
    check("out_valid0", longint'(d0_out_valid), longint'(m_ov[0]));
    check("err_drop0",  longint'(d0_err_drop),  longint'(m_err[0]));
    check("out_valid1", longint'(d1_out_valid), longint'(m_ov[1]));
    check("err_drop1",  longint'(d1_err_drop),  longint'(m_err[1]));
    if (m_ov[0]) begin
      check("out_sum0", longint'(d0_out_sum),      m_sum[0]);
      check("out_ovf0", longint'(d0_out_overflow), longint'(m_of[0]));
    end
    if (m_ov[1]) begin
      check("out_sum1", longint'(d1_out_sum),      m_sum[1]);
      check("out_ovf1", longint'(d1_out_overflow), longint'(m_of[1]));
    end
  endtask

  task automatic put(input int id, input int p, input bit c);
    vld_a[id]  = 1'b1;
    prod_a[id] = 16'(p);
    clr_a[id]  = c;
    cycle();
    vld_a[id]  = 1'b0;
    clr_a[id]  = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst_a[i] = 1'b1; vld_a[i] = 1'b0; clr_a[i] = 1'b0;
      ordy_a[i] = 1'b1; prod_a[i] = 16'h0000;
      m_ov[i] = 0; m_sum[i] = 0; m_of[i] = 0; m_err[i] = 0;
      g_sum[i] = 0; g_n[i] = 0;
    end
    @(negedge clk);
    cycle();
    cycle();
    check("reset_valid", longint'(d0_out_valid), 0);
    check("reset_sum",   longint'(d0_out_sum),   0);
    check("reset_ovf",   longint'(d0_out_overflow), 0);
    check("reset_err",   longint'(d0_err_drop),  0);
    check("reset_rdy",   longint'(d0_in_ready),  1);
    rst_a[0] = 1'b0;
    rst_a[1] = 1'b0;

    // Basic group
    put(0, 15, 0); put(0, 100, 0); put(0, 0, 0);
    check("basic_early", longint'(d0_out_valid), 0);
    put(0, 9, 0);
    check("basic_valid", longint'(d0_out_valid), 1);
    check("basic_sum",   longint'(d0_out_sum), 124);
    check("basic_ovf",   longint'(d0_out_overflow), 0);
    cycle();
    check("basic_pulse", longint'(d0_out_valid), 0);

    // Back-to-back groups
    for (int i = 0; i < 8; i++) begin
      check("b2b_ready", longint'(d0_in_ready), 1);
      put(0, 16'hFE01, 0);
      if (i == 3 || i == 7) begin
        check("b2b_valid", longint'(d0_out_valid), 1);
        check("b2b_sum",   longint'(d0_out_sum), 'h3F804);
      end
      if (i == 4) check("b2b_popped", longint'(d0_out_valid), 0);
    end
    cycle();

    // Backpressure
    ordy_a[0] = 1'b0;
    put(0, 1, 0); put(0, 2, 0); put(0, 3, 0); put(0, 4, 0);
    repeat (5) cycle();
    check("bp_valid", longint'(d0_out_valid), 1);
    check("bp_sum",   longint'(d0_out_sum), 10);
    check("bp_ready", longint'(d0_in_ready), 0);
    put(0, 99, 0);
    check("bp_err",      longint'(d0_err_drop), 1);
    check("bp_sum_hold", longint'(d0_out_sum), 10);
    ordy_a[0] = 1'b1;
    cycle();
    check("bp_pop",   longint'(d0_out_valid), 0);
    check("bp_ready2", longint'(d0_in_ready), 1);

    // Overflow on the narrow instance
    put(1, 16'hFF01, 0); put(1, 16'h0100, 0);
    check("ovf_sum",  longint'(d1_out_sum), 1);
    check("ovf_flag", longint'(d1_out_overflow), 1);
    put(1, 1, 0); put(1, 2, 0);
    check("ovf_next_sum",  longint'(d1_out_sum), 3);
    check("ovf_next_flag", longint'(d1_out_overflow), 0);

    // clr together with an accepted product
    put(0, 5, 0); put(0, 6, 0); put(0, 7, 1);
    check("clr_novalid", longint'(d0_out_valid), 0);
    put(0, 1, 0); put(0, 1, 0); put(0, 1, 0);
    check("clr_valid", longint'(d0_out_valid), 1);
    check("clr_sum",   longint'(d0_out_sum), 10);

    // Reset while a partial group and a pending result are held
    put(0, 3, 0); put(0, 3, 0);
    ordy_a[0] = 1'b0;
    put(0, 3, 0); put(0, 3, 0);
    put(0, 8, 0); put(0, 8, 0);
    check("rst_pend", longint'(d0_out_valid), 1);
    rst_a[0] = 1'b1;
    cycle();
    rst_a[0] = 1'b0;
    check("rst_valid", longint'(d0_out_valid), 0);
    check("rst_err",   longint'(d0_err_drop), 0);
    ordy_a[0] = 1'b1;
    put(0, 10, 0); put(0, 20, 0); put(0, 30, 0); put(0, 40, 0);
    check("rst_fresh_sum", longint'(d0_out_sum), 100);

    // Randomized traffic on both instances
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 2; i++) begin
        rst_a[i]  = ($urandom_range(0, 299) == 0);
        vld_a[i]  = ($urandom_range(0, 3) != 0);
        clr_a[i]  = ($urandom_range(0, 19) == 0);
        ordy_a[i] = ($urandom_range(0, 3) != 0);
        prod_a[i] = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255));
      end
      cycle();
    end

    for (int i = 0; i < 2; i++) begin
      rst_a[i] = 1'b0; vld_a[i] = 1'b0; clr_a[i] = 1'b0; ordy_a[i] = 1'b1;
    end
    cycle();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
